// File: rtl/ring_bridge_injector.sv
// Cross-ring bridge: pops the connect-router buffer head into a one-entry holding
// register and offers it on the peer ring's inj port until accepted.
`ifndef CONTROL_W
`define CONTROL_W 16
`endif
`ifndef VALID_F
`define VALID_F 15
`endif
`ifndef DEST_F
`define DEST_F 14:12
`endif

module ring_bridge_injector #(
  parameter int STARVE_LIMIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [`CONTROL_W-1:0] buf_out,
  input  logic [2:0]            buf_size,
  input  logic                  buf_full,
  output logic                  buf_pop,
  output logic [`CONTROL_W-1:0] inj_out,
  input  logic                  inj_accept,
  output logic                  starve,
  output logic                  busy,
  output logic [CNT_W-1:0]      fwd_cnt,
  output logic [CNT_W-1:0]      drop_cnt
);

  localparam int WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = (STARVE_LIMIT > 1) ? WAIT_W'(STARVE_LIMIT - 1) : '0;

  typedef enum logic [1:0] {
    S_EMPTY  = 2'd0,
    S_HOLD   = 2'd1,
    S_STARVE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [`CONTROL_W-1:0]   hold_q, hold_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [CNT_W-1:0]        fwd_cnt_q, fwd_cnt_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;

  logic                    held;
  logic                    fwd_fire;
  logic                    load;
  logic                    head_valid;
  logic [WAIT_W-1:0]       wait_inc;
  logic                    unused_buf_full;

  // Occupancy alone drives popping; the full flag is informational only.
  assign unused_buf_full = buf_full;

  assign held       = (state_q != S_EMPTY);
  assign fwd_fire   = held && inj_accept;
  assign load       = (buf_size != 3'd0) && ((state_q == S_EMPTY) || inj_accept);
  assign head_valid = buf_out[`VALID_F];
  assign wait_inc   = wait_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_EMPTY;
      hold_q     <= '0;
      wait_q     <= '0;
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      wait_q     <= wait_d;
      fwd_cnt_q  <= fwd_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (load) begin
      if (!head_valid)
        state_d = S_EMPTY;
      else if (WAIT_MAX == '0)
        state_d = S_STARVE;
      else
        state_d = S_HOLD;
    end else if (fwd_fire) begin
      state_d = S_EMPTY;
    end else if ((state_q == S_HOLD) && (wait_inc == WAIT_MAX)) begin
      state_d = S_STARVE;
    end
  end

  // A load in the accept cycle replaces the outgoing flit, giving one flit per cycle.
  always_comb begin
    hold_d     = hold_q;
    wait_d     = wait_q;
    fwd_cnt_d  = fwd_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (fwd_fire)
      fwd_cnt_d = fwd_cnt_q + 1'b1;
    if (load) begin
      if (head_valid) begin
        hold_d = buf_out;
        wait_d = '0;
      end else begin
        hold_d     = '0;
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end else if (fwd_fire) begin
      hold_d = '0;
    end else if (state_q == S_HOLD) begin
      wait_d = wait_inc;
    end
  end

  always_comb begin
    buf_pop  = load && rst;
    busy     = held;
    starve   = (state_q == S_STARVE);
    inj_out  = hold_q;
    fwd_cnt  = fwd_cnt_q;
    drop_cnt = drop_cnt_q;
  end

endmodule

// File: tb/tb_ring_bridge_injector.sv
// Bench for ring_bridge_injector: behavioural buffer model feeding the DUT,
// scoreboard of expected injected flits, directed timing/counter checks.
`ifndef CONTROL_W
`define CONTROL_W 16
`endif
`ifndef VALID_F
`define VALID_F 15
`endif

module tb_ring_bridge_injector;

  logic                  clk;
  logic                  rst;
  logic [`CONTROL_W-1:0] buf_out;
  logic [2:0]            buf_size;
  logic                  buf_full;
  logic                  buf_pop;
  logic [`CONTROL_W-1:0] inj_out;
  logic                  inj_accept;
  logic                  starve;
  logic                  busy;
  logic [3:0]            fwd_cnt;
  logic [3:0]            drop_cnt;

  ring_bridge_injector #(.STARVE_LIMIT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .buf_out(buf_out), .buf_size(buf_size), .buf_full(buf_full),
    .buf_pop(buf_pop), .inj_out(inj_out), .inj_accept(inj_accept), .starve(starve),
    .busy(busy), .fwd_cnt(fwd_cnt), .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int pops   = 0;

  logic [`CONTROL_W-1:0] bufq[$];
  logic [`CONTROL_W-1:0] pend[$];
  logic [`CONTROL_W-1:0] expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [`CONTROL_W-1:0] mk(input logic [2:0] d, input logic [11:0] p);
    return {1'b1, d, p};
  endfunction

  task automatic push(input logic [`CONTROL_W-1:0] f);
    pend.push_back(f);
    if (f[`VALID_F]) expq.push_back(f);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Buffer model: pop on the edge where buf_pop was high, then admit pending pushes.
  initial begin
    buf_out = '0; buf_size = '0; buf_full = 1'b0;
  end

  always @(posedge clk) begin
    logic pop_now;
    logic [`CONTROL_W-1:0] tmp;
    pop_now = buf_pop;
    if (pop_now) pops++;
    #1;
    if (pop_now) begin
      if (bufq.size() == 0) chk("pop_on_empty", 32'd1, 32'd0);
      else tmp = bufq.pop_front();
    end
    while (pend.size() != 0 && bufq.size() < 7) bufq.push_back(pend.pop_front());
    buf_size = 3'(bufq.size());
    buf_full = (bufq.size() == 7);
    buf_out  = (bufq.size() != 0) ? bufq[0] : '0;
  end

  // Scoreboard monitor: every accepted offer must match the next expected flit.
  always @(negedge clk) begin
    logic [`CONTROL_W-1:0] e;
    if (rst) begin
      if (busy && inj_accept) begin
        if (expq.size() == 0) chk("unexpected_flit", 32'(inj_out), 32'd0);
        else begin
          e = expq.pop_front();
          chk("sb_flit", 32'(inj_out), 32'(e));
        end
      end else if (!busy) begin
        chk("idle_inj_zero", 32'(inj_out), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p0;
  logic [`CONTROL_W-1:0] f_single, g_starve, h_rst;

  initial begin
    rst = 1'b0;
    inj_accept = 1'b0;
    f_single = mk(3'd5, 12'h0A5);
    g_starve = mk(3'd2, 12'h3C3);
    h_rst    = mk(3'd7, 12'hFFF);

    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_inj", 32'(inj_out), 32'd0);
    chk("rst_pop", 32'(buf_pop), 32'd0);
    chk("rst_fwd", 32'(fwd_cnt), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // single flit
    p0 = pops;
    push(f_single);
    tick();
    chk("single_pop", 32'(buf_pop), 32'd1);
    chk("single_not_busy_yet", 32'(busy), 32'd0);
    tick();
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_inj", 32'(inj_out), 32'(f_single));
    chk("single_pop_count", 32'(pops - p0), 32'd1);
    inj_accept = 1'b1;
    tick();
    inj_accept = 1'b0;
    chk("single_fwd", 32'(fwd_cnt), 32'd1);
    chk("single_inj_after", 32'(inj_out), 32'd0);
    chk("single_idle", 32'(busy), 32'd0);

    // accept while empty is ignored
    inj_accept = 1'b1;
    tick();
    chk("empty_accept_fwd", 32'(fwd_cnt), 32'd1);

    // streaming 7 flits with accept held high
    p0 = pops;
    for (int i = 0; i < 7; i++) push(mk(3'(i), 12'(12'h100 + i)));
    tick();
    tick();
    chk("stream_first", 32'(inj_out), 32'(mk(3'd0, 12'h100)));
    repeat (6) tick();
    chk("stream_last", 32'(inj_out), 32'(mk(3'd6, 12'h106)));
    tick();
    chk("stream_idle", 32'(busy), 32'd0);
    chk("stream_fwd", 32'(fwd_cnt), 32'd8);
    chk("stream_pops", 32'(pops - p0), 32'd7);
    inj_accept = 1'b0;

    // starvation with STARVE_LIMIT=4
    push(g_starve);
    tick(); tick();
    chk("starve_c1", 32'(starve), 32'd0);
    tick(); tick();
    chk("starve_c3", 32'(starve), 32'd0);
    tick();
    chk("starve_c4", 32'(starve), 32'd1);
    repeat (4) tick();
    chk("starve_stays", 32'(starve), 32'd1);
    chk("starve_inj", 32'(inj_out), 32'(g_starve));
    inj_accept = 1'b1;
    tick();
    inj_accept = 1'b0;
    chk("starve_clear", 32'(starve), 32'd0);
    chk("starve_busy_clear", 32'(busy), 32'd0);
    chk("starve_fwd", 32'(fwd_cnt), 32'd9);

    // invalid entry discarded
    p0 = pops;
    push(16'h0123);
    tick();
    chk("inv_pop", 32'(buf_pop), 32'd1);
    tick();
    chk("inv_drop", 32'(drop_cnt), 32'd1);
    chk("inv_busy", 32'(busy), 32'd0);
    chk("inv_inj", 32'(inj_out), 32'd0);
    chk("inv_pops", 32'(pops - p0), 32'd1);
    tick();
    chk("inv_stays_empty", 32'(busy), 32'd0);

    // asynchronous reset mid-hold
    push(h_rst);
    tick(); tick(); tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk("async_rst_inj", 32'(inj_out), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_fwd", 32'(fwd_cnt), 32'd0);
    chk("async_rst_drop", 32'(drop_cnt), 32'd0);
    expq.delete();
    #1;
    tick();
    chk("in_rst_pop", 32'(buf_pop), 32'd0);
    rst = 1'b1;
    tick();
    chk("post_rst_pop", 32'(buf_pop), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    // 17 accepted flits wrap a 4-bit counter to 1
    inj_accept = 1'b1;
    for (int i = 0; i < 7; i++) push(mk(3'd1, 12'(12'h200 + i)));
    repeat (9) tick();
    for (int i = 0; i < 7; i++) push(mk(3'd3, 12'(12'h300 + i)));
    repeat (9) tick();
    for (int i = 0; i < 3; i++) push(mk(3'd4, 12'(12'h400 + i)));
    repeat (6) tick();
    inj_accept = 1'b0;
    chk("wrap_fwd", 32'(fwd_cnt), 32'd1);
    chk("wrap_drop", 32'(drop_cnt), 32'd0);
    chk("wrap_idle", 32'(busy), 32'd0);
    tick();
    chk("sb_drained", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
